regfile_wb_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_defer_ctr.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    // One writeback request: destination register plus the value to write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

    // PRIO_LSU: normal fixed-priority mode; FORCE_ALU: one-shot ALU grant.
    typedef enum logic {
        PRIO_LSU  = 1'b0,
        FORCE_ALU = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_defer_ctr.sv
// Saturating count of consecutive cycles the ALU lost arbitration.
// hit is a look-ahead: it is high in the cycle whose increment brings the
// count to MAX_DEFER, so the arbiter can switch to FORCE_ALU on that edge.
module wb_defer_ctr #(
    parameter int MAX_DEFER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int            CW       = $clog2(MAX_DEFER + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DEFER);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DEFER - 1);

    logic [CW-1:0] cnt;

    assign hit = inc && (cnt == CNT_LAST);

    // Count deferrals; clear wins over increment, and the count never wraps.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop updates from pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and the
// LSU load-return path: LSU has priority, the ALU is force-granted after
// MAX_DEFER consecutive losses, and writes to x0 are swallowed.
// Optional macro WB_ARB_STATS_EN adds the stat_defer_cnt output.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int MAX_DEFER = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  wb_wv,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic [31:0]           rd_pending
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]           stat_defer_cnt
`endif
);

    arb_state_e state, state_nxt;
    logic       alu_req, lsu_req, same_rd;
    logic       grant_alu, grant_lsu;
    logic       defer_inc, defer_clr, defer_hit;

    // Only requests to a real register compete; x0 requests are absorbed.
    assign alu_req = alu_valid && (alu_rd != '0);
    assign lsu_req = lsu_valid && (lsu_rd != '0);
    assign same_rd = alu_req && lsu_req && (alu_rd == lsu_rd);

    // Grant selection: LSU first, except a forced ALU grant that does not
    // collide with an LSU write to the same register.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (state == FORCE_ALU) begin
            grant_alu = alu_req && !same_rd;
            grant_lsu = lsu_req && !grant_alu;
        end else begin
            grant_lsu = lsu_req;
            grant_alu = alu_req && !lsu_req;
        end
    end

    assign alu_ready = (alu_valid && (alu_rd == '0)) || grant_alu;
    assign lsu_ready = (lsu_valid && (lsu_rd == '0)) || grant_lsu;

    assign defer_inc = (state == PRIO_LSU) && alu_req && !grant_alu;
    assign defer_clr = (state == FORCE_ALU) || grant_alu || !alu_valid;

    wb_defer_ctr #(.MAX_DEFER(MAX_DEFER)) u_defer_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (defer_inc),
        .clr   (defer_clr),
        .hit   (defer_hit)
    );

    // Arbitration mode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PRIO_LSU;
        end else begin
            state <= state_nxt;
        end
    end

    // FORCE_ALU lasts one cycle unless a same-rd collision pushes it back.
    always_comb begin
        state_nxt = state;
        case (state)
            PRIO_LSU:  if (defer_hit) state_nxt = FORCE_ALU;
            FORCE_ALU: state_nxt = same_rd ? FORCE_ALU : PRIO_LSU;
            default:   state_nxt = PRIO_LSU;
        endcase
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_wv   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (grant_alu) begin
            wb_wv   <= 1'b1;
            wb_addr <= alu_rd;
            wb_data <= alu_data;
        end else if (grant_lsu) begin
            wb_wv   <= 1'b1;
            wb_addr <= lsu_rd;
            wb_data <= lsu_data;
        end else begin
            wb_wv   <= 1'b0;
        end
    end

    // Registers with a write still waiting for arbitration or in flight.
    always_comb begin
        rd_pending = '0;
        if (alu_req && !grant_alu) rd_pending[alu_rd] = 1'b1;
        if (lsu_req && !grant_lsu) rd_pending[lsu_rd] = 1'b1;
        if (wb_wv)                 rd_pending[wb_addr] = 1'b1;
        rd_pending[0] = 1'b0;
    end

`ifdef WB_ARB_STATS_EN
    // Total cycles the ALU waited with a real request, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_defer_cnt <= '0;
        end else if (alu_req && !grant_alu && (stat_defer_cnt != 32'hFFFF_FFFF)) begin
            stat_defer_cnt <= stat_defer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of single-cycle
// vectors, hand-written multi-cycle sequences, and random traffic checked
// against a rule-level reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import wb_arb_pkg::*;

    localparam int XLEN      = 32;
    localparam int MAX_DEFER = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]       alu_rd, lsu_rd, wb_addr;
    logic [XLEN-1:0]  alu_data, lsu_data, wb_data;
    logic             wb_wv;
    logic [31:0]      rd_pending;
`ifdef WB_ARB_STATS_EN
    logic [31:0]      stat_defer_cnt;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .MAX_DEFER(MAX_DEFER)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .wb_wv      (wb_wv),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rd_pending (rd_pending)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_defer_cnt (stat_defer_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register file shadow written from the DUT's write port.
    logic [31:0] shadow [32];
    always @(posedge clk) if (wb_wv) shadow[wb_addr] <= wb_data;

    // ---------------- reference model (rule level) ----------------
    int          m_streak;   // consecutive ALU losses in normal mode
    bit          m_force;    // next cycle owes the ALU a grant
    bit          m_wv;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_stat;
    logic [31:0] m_regs [32];
    bit          e_ga, e_gl, e_ar, e_lr;
    logic [31:0] e_pend;

    task automatic model_eval();
        bit a, l;
        a = alu_valid && (alu_rd != 5'd0);
        l = lsu_valid && (lsu_rd != 5'd0);
        if (m_force) begin
            e_ga = a && !(l && (alu_rd == lsu_rd));
            e_gl = l && !e_ga;
        end else begin
            e_gl = l;
            e_ga = a && !l;
        end
        e_ar   = (alu_valid && (alu_rd == 5'd0)) || e_ga;
        e_lr   = (lsu_valid && (lsu_rd == 5'd0)) || e_gl;
        e_pend = 32'd0;
        if (a && !e_ga) e_pend |= 32'd1 << alu_rd;
        if (l && !e_gl) e_pend |= 32'd1 << lsu_rd;
        if (m_wv)       e_pend |= 32'd1 << m_addr;
    endtask

    task automatic model_clock();
        bit a, l, same;
        model_eval();
        a    = alu_valid && (alu_rd != 5'd0);
        l    = lsu_valid && (lsu_rd != 5'd0);
        same = a && l && (alu_rd == lsu_rd);
        if (reset) begin
            m_streak = 0; m_force = 1'b0; m_wv = 1'b0;
            m_addr = 5'd0; m_data = 32'd0; m_stat = 32'd0;
            return;
        end
        if (a && !e_ga && (m_stat != 32'hFFFF_FFFF)) m_stat++;
        if (e_ga) begin
            m_wv = 1'b1; m_addr = alu_rd; m_data = alu_data; m_regs[alu_rd] = alu_data;
        end else if (e_gl) begin
            m_wv = 1'b1; m_addr = lsu_rd; m_data = lsu_data; m_regs[lsu_rd] = lsu_data;
        end else begin
            m_wv = 1'b0;
        end
        if (m_force) begin
            m_force  = same;
            m_streak = 0;
        end else if (a && !e_ga) begin
            m_streak++;
            if (m_streak == MAX_DEFER) begin
                m_force  = 1'b1;
                m_streak = 0;
            end
        end else if (!alu_valid || e_ga) begin
            m_streak = 0;
        end
    endtask

    // One clock cycle: inputs were set just after the previous edge.
    task automatic step(input bit do_check, input string tag);
        #1;
        model_eval();
        if (do_check) begin
            check({tag, " alu_ready"},  32'(alu_ready), 32'(e_ar));
            check({tag, " lsu_ready"},  32'(lsu_ready), 32'(e_lr));
            check({tag, " rd_pending"}, rd_pending, e_pend);
            check({tag, " wb_wv"},      32'(wb_wv), 32'(m_wv));
            check({tag, " wb_addr"},    32'(wb_addr), 32'(m_addr));
            check({tag, " wb_data"},    wb_data, m_data);
`ifdef WB_ARB_STATS_EN
            check({tag, " stat"},       stat_defer_cnt, m_stat);
`endif
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_in(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                          input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    // ALU held on ard while LSU streams accepted requests (rd 1..8).
    task automatic starve(input string tag, input logic [4:0] ard);
        int         grant_at;
        logic [4:0] lrd;
        grant_at = -1;
        lrd      = 5'd1;
        set_in(1'b1, ard, 32'hA000_0000 + 32'(ard), 1'b1, lrd, 32'h100);
        for (int c = 1; c <= 20 && grant_at < 0; c++) begin
            #1;
            if (alu_ready) grant_at = c;
            step(1'b1, tag);
            if (e_lr) begin
                lrd      = (lrd == 5'd8) ? 5'd1 : lrd + 5'd1;
                lsu_rd   = lrd;
                lsu_data = 32'h100 + 32'(c);
            end
            if (e_ar) alu_valid = 1'b0;
        end
        check({tag, " grant cycle"}, 32'(grant_at), 32'd5);
`ifdef WB_ARB_STATS_EN
        check({tag, " stat after"}, stat_defer_cnt, 32'd4);
`endif
        step(1'b1, tag);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        bit          alu_v;
        wb_req_t     alu;
        bit          lsu_v;
        wb_req_t     lsu;
        bit          exp_ar;
        bit          exp_lr;
        logic [31:0] exp_pend;
        bit          exp_wv;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    bit a_hold, l_hold;

    initial begin
        vecs[0] = '{1'b1, '{rd: 5'd5,  data: 32'h1234}, 1'b0, '{rd: 5'd0,  data: 32'h0},
                    1'b1, 1'b0, 32'h0,    1'b1, 5'd5,  32'h1234};
        vecs[1] = '{1'b1, '{rd: 5'd3,  data: 32'hA3},   1'b1, '{rd: 5'd7,  data: 32'hB7},
                    1'b0, 1'b1, 32'h8,    1'b1, 5'd7,  32'hB7};
        vecs[2] = '{1'b1, '{rd: 5'd0,  data: 32'hDEAD}, 1'b1, '{rd: 5'd0,  data: 32'hBEEF},
                    1'b1, 1'b1, 32'h0,    1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, '{rd: 5'd0,  data: 32'h11},   1'b1, '{rd: 5'd9,  data: 32'h99},
                    1'b1, 1'b1, 32'h0,    1'b1, 5'd9,  32'h99};
        vecs[4] = '{1'b1, '{rd: 5'd12, data: 32'hC1},   1'b1, '{rd: 5'd12, data: 32'hC2},
                    1'b0, 1'b1, 32'h1000, 1'b1, 5'd12, 32'hC2};
        vecs[5] = '{1'b0, '{rd: 5'd4,  data: 32'h44},   1'b1, '{rd: 5'd31, data: 32'h31},
                    1'b0, 1'b1, 32'h0,    1'b1, 5'd31, 32'h31};
        vecs[6] = '{1'b1, '{rd: 5'd31, data: 32'h7F},   1'b1, '{rd: 5'd0,  data: 32'h5},
                    1'b1, 1'b1, 32'h0,    1'b1, 5'd31, 32'h7F};
        vecs[7] = '{1'b0, '{rd: 5'd4,  data: 32'h1},    1'b0, '{rd: 5'd6,  data: 32'h2},
                    1'b0, 1'b0, 32'h0,    1'b0, 5'd0,  32'h0};

        for (int i = 0; i < 32; i++) begin
            shadow[i] = 32'd0;
            m_regs[i] = 32'd0;
        end
        m_streak = 0; m_force = 1'b0; m_wv = 1'b0;
        m_addr = 5'd0; m_data = 32'd0; m_stat = 32'd0;
        reset = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b0, "init");
        step(1'b0, "init");

        // Reset state of the registered outputs.
        check("reset wb_wv",   32'(wb_wv), 32'd0);
        check("reset wb_addr", 32'(wb_addr), 32'd0);
        check("reset wb_data", wb_data, 32'd0);

        // Table: each vector starts from a freshly reset arbiter.
        for (int i = 0; i < NVEC; i++) begin
            reset = 1'b1;
            set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            step(1'b0, "vrst");
            reset = 1'b0;
            set_in(vecs[i].alu_v, vecs[i].alu.rd, vecs[i].alu.data,
                   vecs[i].lsu_v, vecs[i].lsu.rd, vecs[i].lsu.data);
            #1;
            check($sformatf("v%0d alu_ready", i),  32'(alu_ready), 32'(vecs[i].exp_ar));
            check($sformatf("v%0d lsu_ready", i),  32'(lsu_ready), 32'(vecs[i].exp_lr));
            check($sformatf("v%0d rd_pending", i), rd_pending, vecs[i].exp_pend);
            step(1'b1, "vec");
            reset = 1'b1;
            set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            #1;
            check($sformatf("v%0d wb_wv", i),   32'(wb_wv), 32'(vecs[i].exp_wv));
            check($sformatf("v%0d wb_addr", i), 32'(wb_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d wb_data", i), wb_data, vecs[i].exp_data);
        end
        step(1'b0, "rst");
        reset = 1'b0;

        // Starvation guard: ALU forced through on the fifth cycle.
        starve("starve", 5'd9);

        // Same-rd collision while forced: LSU write lands first, ALU last.
        reset = 1'b1;
        step(1'b1, "rst");
        reset = 1'b0;
        for (int c = 0; c < MAX_DEFER; c++) begin
            set_in(1'b1, 5'd12, 32'hA1A1, 1'b1, 5'(c + 1), 32'(c));
            step(1'b1, "pre_force");
        end
        set_in(1'b1, 5'd12, 32'hA1A1, 1'b1, 5'd12, 32'h5151);
        #1;
        check("coll alu_ready", 32'(alu_ready), 32'd0);
        check("coll lsu_ready", 32'(lsu_ready), 32'd1);
        step(1'b1, "coll");
        check("coll first wb_addr", 32'(wb_addr), 32'd12);
        check("coll first wb_data", wb_data, 32'h5151);
        set_in(1'b1, 5'd12, 32'hA1A1, 1'b1, 5'd13, 32'h1313);
        #1;
        check("coll2 alu_ready", 32'(alu_ready), 32'd1);
        check("coll2 lsu_ready", 32'(lsu_ready), 32'd0);
        step(1'b1, "coll2");
        check("coll second wb_data", wb_data, 32'hA1A1);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h1313);
        step(1'b1, "coll3");
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, "coll4");
        check("x12 final", shadow[12], 32'hA1A1);

        // Reset with the ALU waiting and a write in flight.
        set_in(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
        step(1'b1, "midop");
        lsu_rd = 5'd22; lsu_data = 32'h2222;
        step(1'b1, "midop");
        reset = 1'b1;
        lsu_rd = 5'd23; lsu_data = 32'h2323;
        step(1'b1, "midop_rst");
        reset = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        check("post_rst wb_wv", 32'(wb_wv), 32'd0);
        check("post_rst rd_pending", rd_pending, 32'd0);
        step(1'b1, "post_rst");
        starve("after_rst", 5'd24);

        // Random traffic against the model; requesters honour the handshake.
        a_hold = 1'b0;
        l_hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!a_hold) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!l_hold) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            step(1'b1, "rand");
            a_hold = alu_valid && !e_ar && !reset;
            l_hold = lsu_valid && !e_lr && !reset;
        end
        reset = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, "drain");
        step(1'b1, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
